// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Purpose  : Data-memory target for the CPU load/store path. Accepts one
//             word request at a time over valid/ready, waits LATENCY cycles,
//             then returns load data or a store acknowledgement with an
//             error flag. Backed by an on-chip word RAM of 2**DEPTH_LOG2
//             words.
//  Ports    : clk, rst                 - clock, synchronous active-high reset
//             req_valid / req_ready    - request handshake (ready only in IDLE)
//             req_we, req_addr,
//             req_wdata, req_be        - request payload (byte address)
//             rsp_valid / rsp_ready    - response handshake
//             rsp_rdata, rsp_err       - load data (0 for stores/errors), error
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_responder #(
  parameter int n          = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [n-1:0]     req_addr,
  input  logic [n-1:0]     req_wdata,
  input  logic [3:0]       req_be,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [n-1:0]     rsp_rdata,
  output logic             rsp_err
);

  localparam int C_DEPTH = 1 << DEPTH_LOG2;
  // The WAIT counter runs 0 .. LATENCY-2, so it needs width for LATENCY-2.
  localparam int C_CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);
  // With LATENCY==1 the accept edge itself enters RESP.
  localparam bit C_SKIP_WAIT = (LATENCY <= 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                state_q;
  logic [C_CNT_W-1:0]    cnt_q;
  logic                  we_q;
  logic [n-1:0]          addr_q;
  logic [n-1:0]          wdata_q;
  logic [3:0]            be_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic [n-1:0]          rsp_rdata_q;
  logic                  rsp_err_q;
  logic [n-1:0]          mem_q [C_DEPTH];

  logic                  w_accept;
  logic                  w_enter_resp;
  logic                  w_acc_we;
  logic [n-1:0]          w_acc_addr;
  logic [n-1:0]          w_acc_wdata;
  logic [3:0]            w_acc_be;
  logic                  w_acc_err;
  logic [DEPTH_LOG2-1:0] w_acc_idx;
  logic                  w_commit;

  assign w_accept = req_valid && req_ready_q && (state_q == S_IDLE);

  // The RAM access happens on the edge that enters RESP. That is the accept
  // edge itself when there is no WAIT phase, so the access operands come
  // straight from the request port in IDLE and from the latched copy after.
  assign w_acc_we    = (state_q == S_IDLE) ? req_we    : we_q;
  assign w_acc_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign w_acc_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
  assign w_acc_be    = (state_q == S_IDLE) ? req_be    : be_q;

  assign w_enter_resp = (w_accept && C_SKIP_WAIT) ||
                        ((state_q == S_WAIT) && (cnt_q == C_CNT_LAST));

  assign w_acc_idx = w_acc_addr[DEPTH_LOG2+1:2];
  assign w_acc_err = (w_acc_addr[1:0] != 2'b00) ||
                     (w_acc_addr[n-1:DEPTH_LOG2+2] != '0);

  // Reset wins over the commit edge so a store caught in WAIT is dropped.
  assign w_commit = w_enter_resp && w_acc_we && !w_acc_err && !rst;

  // Word RAM with per-byte write enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_acc_be[b]) begin
          mem_q[w_acc_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= 4'b0000;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (w_accept) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            be_q        <= req_be;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            state_q     <= C_SKIP_WAIT ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == C_CNT_LAST) begin
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          // Response outputs hold until the initiator takes them.
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b0;
        end
      endcase

      // Load the response on the edge that enters RESP; the RAM read here
      // sees every store committed on an earlier edge.
      if (w_enter_resp) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= w_acc_err;
        rsp_rdata_q <= (w_acc_we || w_acc_err) ? '0 : mem_q[w_acc_idx];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Purpose  : Directed self-checking bench for data_mem_responder. One
//             instance uses LATENCY=2, a second uses LATENCY=1 for the
//             back-to-back throughput case. Inputs are driven and outputs
//             sampled on the falling clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

  logic        clk;
  logic        rst;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;

  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_be;

  int r_errors;
  int r_checks;

  data_mem_responder #(.n(32), .DEPTH_LOG2(8), .LATENCY(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  data_mem_responder #(.n(32), .DEPTH_LOG2(8), .LATENCY(1)) u_dut_l1 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_we    (b_req_we),
    .req_addr  (b_req_addr),
    .req_wdata (b_req_wdata),
    .req_be    (b_req_be),
    .rsp_valid (b_rsp_valid),
    .rsp_ready (b_rsp_ready),
    .rsp_rdata (b_rsp_rdata),
    .rsp_err   (b_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    r_checks++;
    if (got !== exp) begin
      r_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a request (called at a falling edge), hold it through the accept
  // edge, then scramble the payload since it is don't-care afterwards.
  task automatic send(input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be);
    int k;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) check("accept_timeout", 32'(k), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
  endtask

  // Count falling edges from the one after the accept edge until rsp_valid.
  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input logic [31:0] exp_rdata, input logic exp_err);
    int cyc;
    send(we, addr, wdata, be);
    wait_rsp(cyc);
    check({tag, "_lat"},   32'(cyc), 32'd2);
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_err"},   {31'd0, rsp_err}, {31'd0, exp_err});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rdy_back"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] s_rdata;
    logic        s_err;
    int          cyc;
    int          idx;
    int          ridx;
    bit          pending;
    int          acc_cyc [4];
    logic        s_we    [4];
    logic [31:0] s_addr  [4];
    logic [31:0] s_wdata [4];
    logic [31:0] s_exp   [4];

    r_errors = 0;
    r_checks = 0;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0; b_rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rdy_rise", {31'd0, req_ready}, 32'd1);
    check("rst_b_rdy",    {31'd0, b_req_ready}, 32'd1);

    // 1: full store then load
    txn("t1_st",   1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0,        1'b0);
    txn("t1_st14", 1'b1, 32'h14, 32'h5555AAAA, 4'b1111, 32'h0,        1'b0);
    txn("t1_ld",   1'b0, 32'h10, 32'h0,        4'b0000, 32'hDEADBEEF, 1'b0);

    // 2: partial byte store
    txn("t2_st",   1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'h0,        1'b0);
    txn("t2_ld",   1'b0, 32'h10, 32'h0,        4'b0000, 32'hDEADBEAA, 1'b0);

    // 3: errors leave RAM alone; be=0 store is a legal no-op
    txn("t3_mis",  1'b0, 32'h12,  32'h0,        4'b0000, 32'h0,        1'b1);
    txn("t3_oor",  1'b0, 32'h400, 32'h0,        4'b0000, 32'h0,        1'b1);
    txn("t3_oorw", 1'b1, 32'h410, 32'hFFFFFFFF, 4'b1111, 32'h0,        1'b1);
    txn("t3_misw", 1'b1, 32'h11,  32'hFFFFFFFF, 4'b1111, 32'h0,        1'b1);
    txn("t3_be0",  1'b1, 32'h10,  32'h00000000, 4'b0000, 32'h0,        1'b0);
    txn("t3_ld",   1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEADBEAA, 1'b0);

    // 4: response backpressure with a competing request
    send(1'b0, 32'h10, 32'h0, 4'b0000);
    wait_rsp(cyc);
    check("t4_lat", 32'(cyc), 32'd2);
    s_rdata = rsp_rdata;
    s_err   = rsp_err;
    check("t4_rdata0", s_rdata, 32'hDEADBEAA);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h14; req_be = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("t4_hold_rdata", rsp_rdata, 32'hDEADBEAA);
      check("t4_hold_err",   {31'd0, rsp_err}, {31'd0, s_err});
      check("t4_hold_rdy",   {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("t4_idle_rdy",   {31'd0, req_ready}, 32'd1);
    check("t4_idle_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check("t4_accepted", {31'd0, req_ready}, 32'd0);
    wait_rsp(cyc);
    check("t4b_lat",   32'(cyc), 32'd2);
    check("t4b_rdata", rsp_rdata, 32'h5555AAAA);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // 5: reset during WAIT drops the store
    txn("t5_pre", 1'b1, 32'h20, 32'h0BADF00D, 4'b1111, 32'h0, 1'b0);
    send(1'b1, 32'h20, 32'h12345678, 4'b1111);
    check("t5_in_wait", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("t5_rst_rdy",   {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("t5_post_rdy",   {31'd0, req_ready}, 32'd1);
    check("t5_post_valid", {31'd0, rsp_valid}, 32'd0);
    txn("t5_ld", 1'b0, 32'h20, 32'h0, 4'b0000, 32'h0BADF00D, 1'b0);

    // 6: LATENCY=1 instance streaming with rsp_ready held high
    s_we[0] = 1'b1; s_addr[0] = 32'h0; s_wdata[0] = 32'h11111111; s_exp[0] = 32'h0;
    s_we[1] = 1'b1; s_addr[1] = 32'h4; s_wdata[1] = 32'h22222222; s_exp[1] = 32'h0;
    s_we[2] = 1'b0; s_addr[2] = 32'h0; s_wdata[2] = 32'h0;        s_exp[2] = 32'h11111111;
    s_we[3] = 1'b0; s_addr[3] = 32'h4; s_wdata[3] = 32'h0;        s_exp[3] = 32'h22222222;
    idx = 0; ridx = 0; pending = 1'b0;
    b_rsp_ready = 1'b1;
    b_req_valid = 1'b1; b_req_we = s_we[0]; b_req_addr = s_addr[0];
    b_req_wdata = s_wdata[0]; b_req_be = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      if (pending) begin
        pending = 1'b0;
        if (idx < 4) begin
          b_req_we = s_we[idx]; b_req_addr = s_addr[idx]; b_req_wdata = s_wdata[idx];
        end else begin
          b_req_valid = 1'b0;
        end
      end
      if (b_rsp_valid && ridx < 4) begin
        check("t6_rsp_cycle", 32'(c), 32'(acc_cyc[ridx] + 1));
        check("t6_rdata", b_rsp_rdata, s_exp[ridx]);
        ridx++;
      end
      if (b_req_ready && b_req_valid && idx < 4) begin
        acc_cyc[idx] = c;
        check("t6_acc_cycle", 32'(c), 32'(2 * idx));
        idx++;
        pending = 1'b1;
      end
      @(negedge clk);
    end
    check("t6_accepts",  32'(idx), 32'd4);
    check("t6_responses", 32'(ridx), 32'd4);
    b_rsp_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
    $finish;
  end

endmodule
`default_nettype wire
